imm_ext_ctrl: RTL and testbench

- Decode-stage immediate controller between the IF/ID register and the ID/EX register.
- Classifies each instruction by opcode and selects the extension mode: sign, zero, LUI shift or branch offset.
- Produces the 32-bit immediate and the branch target.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides, so a stalled EX does not drop instructions.

---
 rtl/imm_ext_ctrl_if.sv | 23 ++
 rtl/imm_ext_ctrl.sv | 167 ++++++++++++++++
 tb/tb_imm_ext_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_ctrl_if.sv
// Valid/ready bundle for the decode immediate controller:
// upstream IF/ID side and downstream ID/EX side.
interface imm_ext_ctrl_if;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] ImmOut;
    logic [31:0] BranchTarget;
    logic [2:0]  ImmMode;

    modport master (
        output InValid, Instruction, PCPlus4, OutReady,
        input  InReady, OutValid, ImmOut, BranchTarget, ImmMode
    );

    modport slave (
        input  InValid, Instruction, PCPlus4, OutReady,
        output InReady, OutValid, ImmOut, BranchTarget, ImmMode
    );
endinterface

// File: rtl/imm_ext_ctrl.sv
// Decode-stage immediate extender and branch-target adder
// feeding a 2-entry skid buffer toward the ID/EX register.
module imm_ext_ctrl #(
    parameter int COUNT_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Flush,
    imm_ext_ctrl_if.slave      bus,
    output logic [COUNT_W-1:0] ExtCount
);

    localparam logic [2:0] M_NONE   = 3'd0;
    localparam logic [2:0] M_SIGN   = 3'd1;
    localparam logic [2:0] M_ZERO   = 3'd2;
    localparam logic [2:0] M_LUI    = 3'd3;
    localparam logic [2:0] M_BRANCH = 3'd4;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] bt;
        logic [2:0]  mode;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    entry_t               r_head;
    entry_t               r_skid;
    entry_t               w_head_nx;
    entry_t               w_skid_nx;
    entry_t               w_new;
    logic [COUNT_W-1:0]   r_cnt;

    logic [5:0]  w_op;
    logic [15:0] w_imm16;
    logic [31:0] w_sext;
    logic [31:0] w_boff;
    logic        w_is_sign;
    logic        w_is_zero;
    logic        w_is_lui;
    logic        w_is_br;
    logic        w_push;
    logic        w_pop;
    logic        w_cnt_inc;
    logic        w_unused;

    assign w_op     = bus.Instruction[31:26];
    assign w_imm16  = bus.Instruction[15:0];
    assign w_unused = ^bus.Instruction[25:16];
    assign w_sext   = {{16{w_imm16[15]}}, w_imm16};
    assign w_boff   = {{14{w_imm16[15]}}, w_imm16, 2'b00};

    assign w_is_sign = (w_op[5:2] == 4'b0010)
                     | (w_op[5:4] == 2'b10);
    assign w_is_zero = (w_op == 6'b001100)
                     | (w_op == 6'b001101)
                     | (w_op == 6'b001110);
    assign w_is_lui  = (w_op == 6'b001111);
    assign w_is_br   = (w_op == 6'b000001)
                     | (w_op[5:2] == 4'b0001);

    // Classify the incoming opcode and build the entry to store.
    always_comb begin
        w_new.imm  = '0;
        w_new.mode = M_NONE;
        w_new.bt   = bus.PCPlus4 + w_boff;
        unique case (1'b1)
            w_is_sign: begin
                w_new.imm  = w_sext;
                w_new.mode = M_SIGN;
            end
            w_is_zero: begin
                w_new.imm  = {16'h0000, w_imm16};
                w_new.mode = M_ZERO;
            end
            w_is_lui: begin
                w_new.imm  = {w_imm16, 16'h0000};
                w_new.mode = M_LUI;
            end
            w_is_br: begin
                w_new.imm  = w_boff;
                w_new.mode = M_BRANCH;
            end
            default: begin
                w_new.imm  = '0;
                w_new.mode = M_NONE;
            end
        endcase
    end

    assign bus.InReady      = (r_state != S_TWO);
    assign bus.OutValid     = (r_state != S_EMPTY);
    assign bus.ImmOut       = r_head.imm;
    assign bus.BranchTarget = r_head.bt;
    assign bus.ImmMode      = r_head.mode;
    assign ExtCount         = r_cnt;

    assign w_push = bus.InValid & bus.InReady;
    assign w_pop  = bus.OutValid & bus.OutReady;

    assign w_cnt_inc = w_pop
                     & (r_head.mode != M_NONE)
                     & (r_cnt != {COUNT_W{1'b1}});

    // Next state and buffer contents; flush overrides everything.
    always_comb begin
        w_state_nx = r_state;
        w_head_nx  = r_head;
        w_skid_nx  = r_skid;
        if (Flush) begin
            w_state_nx = S_EMPTY;
            w_head_nx  = '0;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_head_nx  = w_new;
                        w_state_nx = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_head_nx  = w_new;
                    end else if (w_push) begin
                        w_skid_nx  = w_new;
                        w_state_nx = S_TWO;
                    end else if (w_pop) begin
                        w_state_nx = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_head_nx  = r_skid;
                        w_state_nx = S_ONE;
                    end
                end
                default: begin
                    w_state_nx = S_EMPTY;
                end
            endcase
        end
    end

    // State, buffer and counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_head  <= w_head_nx;
            r_skid  <= w_skid_nx;
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Randomized scoreboard bench for imm_ext_ctrl with directed
// corner cases (extension modes, wrap, backpressure, flush, reset).
module tb_imm_ext_ctrl;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] bt;
        logic [2:0]  mode;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Flush;
    logic [CW-1:0] ExtCount;

    imm_ext_ctrl_if bus ();

    imm_ext_ctrl #(.COUNT_W(CW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Flush    (Flush),
        .bus      (bus.slave),
        .ExtCount (ExtCount)
    );

    always #5 Clk = ~Clk;

    exp_t q[$];
    int   mcnt;
    int   nchk;
    int   nerr;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: rules applied with plain integer arithmetic.
    function automatic exp_t ref_model(logic [31:0] ins,
                                       logic [31:0] pc);
        exp_t        e;
        int          op;
        int          s;
        logic [31:0] off;
        op     = int'(ins[31:26]);
        s      = int'($signed(ins[15:0]));
        off    = 32'(s * 4);
        e.bt   = pc + off;
        e.imm  = 32'd0;
        e.mode = 3'd0;
        if ((op >= 8 && op <= 11) || (op >= 32 && op <= 47)) begin
            e.imm  = 32'(s);
            e.mode = 3'd1;
        end else if (op >= 12 && op <= 14) begin
            e.imm  = 32'(int'(ins[15:0]));
            e.mode = 3'd2;
        end else if (op == 15) begin
            e.imm  = 32'(longint'(ins[15:0]) * 65536);
            e.mode = 3'd3;
        end else if (op == 1 || (op >= 4 && op <= 7)) begin
            e.imm  = off;
            e.mode = 3'd4;
        end
        return e;
    endfunction

    function automatic logic [31:0] mk(logic [5:0] op,
                                       logic [15:0] imm);
        return {op, 10'h000, imm};
    endfunction

    // Monitor: compare presented head against the queue, then
    // account for the transfers the next edge will perform.
    always @(negedge Clk) begin
        if (Reset) begin
            exp_t e;
            bit   pop;
            bit   push;
            chk("out_valid", 32'(bus.OutValid), 32'(q.size() != 0));
            chk("in_ready", 32'(bus.InReady), 32'(q.size() < 2));
            chk("ext_count", 32'(ExtCount), 32'(mcnt));
            if (q.size() != 0) begin
                chk("imm_out", bus.ImmOut, q[0].imm);
                chk("branch_tgt", bus.BranchTarget, q[0].bt);
                chk("imm_mode", 32'(bus.ImmMode), 32'(q[0].mode));
            end
            pop  = (q.size() != 0) && bus.OutReady;
            push = bus.InValid && (q.size() < 2);
            if (pop) begin
                if (q[0].mode != 3'd0 && mcnt < CMAX) mcnt++;
                void'(q.pop_front());
            end
            if (Flush) begin
                q.delete();
            end else if (push) begin
                e = ref_model(bus.Instruction, bus.PCPlus4);
                q.push_back(e);
            end
        end
    end

    // Apply one cycle of inputs; returns at posedge+1.
    task automatic drive(input logic v,
                         input logic [31:0] ins,
                         input logic [31:0] pc,
                         input logic rdy,
                         input logic fl);
        bus.InValid     = v;
        bus.Instruction = ins;
        bus.PCPlus4     = pc;
        bus.OutReady    = rdy;
        Flush           = fl;
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] a_w;
    logic [31:0] b_w;
    logic [31:0] c_w;

    initial begin
        nchk = 0;
        nerr = 0;
        mcnt = 0;
        Reset = 1'b0;
        Flush = 1'b0;
        bus.InValid     = 1'b0;
        bus.Instruction = '0;
        bus.PCPlus4     = '0;
        bus.OutReady    = 1'b0;
        #3;
        chk("rst_valid", 32'(bus.OutValid), 32'd0);
        chk("rst_ready", 32'(bus.InReady), 32'd1);
        chk("rst_imm", bus.ImmOut, 32'd0);
        chk("rst_cnt", 32'(ExtCount), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;

        drive(1, mk(6'b001000, 16'hFFFC), 32'h100, 1, 0);
        chk("addi_imm", bus.ImmOut, 32'hFFFFFFFC);
        chk("addi_mode", 32'(bus.ImmMode), 32'd1);
        drive(1, mk(6'b001101, 16'h8001), 32'h104, 1, 0);
        chk("ori_imm", bus.ImmOut, 32'h00008001);
        chk("ori_mode", 32'(bus.ImmMode), 32'd2);
        drive(1, mk(6'b001111, 16'h1234), 32'h108, 1, 0);
        chk("lui_imm", bus.ImmOut, 32'h12340000);
        chk("lui_mode", 32'(bus.ImmMode), 32'd3);
        drive(1, mk(6'b000100, 16'hFFFF), 32'h10, 1, 0);
        chk("beq_imm", bus.ImmOut, 32'hFFFFFFFC);
        chk("beq_bt", bus.BranchTarget, 32'h0000000C);
        chk("beq_mode", 32'(bus.ImmMode), 32'd4);
        drive(1, mk(6'b000101, 16'h0001), 32'hFFFFFFFC, 1, 0);
        chk("bne_wrap", bus.BranchTarget, 32'h00000000);
        drive(0, '0, '0, 1, 0);
        chk("drained", 32'(bus.OutValid), 32'd0);

        a_w = mk(6'b001000, 16'h0011);
        b_w = mk(6'b001100, 16'h00F0);
        c_w = mk(6'b001110, 16'h8000);
        drive(1, a_w, 32'h200, 0, 0);
        drive(1, b_w, 32'h204, 0, 0);
        chk("bp_full", 32'(bus.InReady), 32'd0);
        chk("bp_head_a", bus.ImmOut, 32'h00000011);
        drive(1, c_w, 32'h208, 0, 0);
        chk("bp_hold_rdy", 32'(bus.InReady), 32'd0);
        chk("bp_hold_a", bus.ImmOut, 32'h00000011);
        drive(1, c_w, 32'h208, 1, 0);
        chk("bp_head_b", bus.ImmOut, 32'h000000F0);
        drive(1, c_w, 32'h208, 1, 0);
        chk("bp_head_c", bus.ImmOut, 32'h00008000);
        drive(0, '0, '0, 1, 0);

        drive(1, a_w, 32'h300, 0, 0);
        drive(1, b_w, 32'h304, 0, 0);
        drive(1, c_w, 32'h308, 1, 1);
        chk("fl_valid", 32'(bus.OutValid), 32'd0);
        chk("fl_ready", 32'(bus.InReady), 32'd1);
        chk("fl_clear", bus.ImmOut, 32'd0);
        drive(0, '0, '0, 1, 0);

        drive(1, a_w, 32'h400, 0, 0);
        drive(1, b_w, 32'h404, 0, 0);
        bus.InValid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.OutValid), 32'd0);
        chk("ar_ready", 32'(bus.InReady), 32'd1);
        chk("ar_imm", bus.ImmOut, 32'd0);
        chk("ar_cnt", 32'(ExtCount), 32'd0);
        q.delete();
        mcnt = 0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;

        drive(1, mk(6'b000000, 16'h1234), 32'h500, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, mk(6'b100011, 16'(i)), 32'h504, 1, 0);
            if (i == 2) chk("sat_none", 32'(ExtCount), 32'd2);
        end
        drive(0, '0, '0, 1, 0);
        drive(0, '0, '0, 1, 0);
        chk("sat_max", 32'(ExtCount), 32'd3);

        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  $urandom(), $urandom(),
                  1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 4; i++) drive(0, '0, '0, 1, 0);
        chk("final_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
